// File: rtl/instr_decode_issue.sv
// instr_decode_issue: fetch / decode / issue / write-back sequencer with an
// 8x16 register file feeding an external ALU.
// Optional feature: define ISSUE_R0_ZERO_EN to hardwire R0 to zero.
module instr_decode_issue #(
  parameter logic [7:0]  START_PC = 8'h00,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [3:0]  alu_opcode,
  output logic [2:0]  alu_func,
  output logic [15:0] alu_reg2,
  output logic [15:0] alu_reg3,
  output logic [8:0]  alu_j_address,
  output logic        alu_valid,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_status,
  output logic        busy,
  output logic        halted,
  output logic        fetch_err,
  output logic [15:0] instr_count
);

  localparam int unsigned WW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WB, S_HALT
  } state_e;

  state_e       state_q;
  logic [7:0]   pc_q;
  logic [WW-1:0] wait_q;
  logic [15:0]  instr_q;
  logic [2:0]   rd_q;
  logic [3:0]   alu_opcode_q;
  logic [2:0]   alu_func_q;
  logic [15:0]  alu_reg2_q;
  logic [15:0]  alu_reg3_q;
  logic [8:0]   alu_j_address_q;
  logic         alu_valid_q;
  logic         fetch_err_q;
  logic [15:0]  instr_count_q;
  logic [15:0]  rf_q [8];

  logic [15:0]  rs1_val;
  logic [15:0]  rs2_val;
  logic         wr_en;

  // Register-file read ports for the instruction held in DECODE
  always_comb begin
    rs1_val = rf_q[instr_q[8:6]];
    rs2_val = rf_q[instr_q[5:3]];
`ifdef ISSUE_R0_ZERO_EN
    if (instr_q[8:6] == 3'd0) rs1_val = '0;
    if (instr_q[5:3] == 3'd0) rs2_val = '0;
`endif
  end

  // Write-back enable: only the result-producing opcodes update R[rd]
  always_comb begin
    wr_en = alu_opcode_q inside {[4'h0:4'h7], 4'h9, 4'hB, 4'hC, 4'hD};
`ifdef ISSUE_R0_ZERO_EN
    if (rd_q == 3'd0) wr_en = 1'b0;
`endif
  end

  // Sequencer, PC, register file and registered ALU-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pc_q            <= START_PC;
      wait_q          <= '0;
      instr_q         <= '0;
      rd_q            <= '0;
      alu_opcode_q    <= '0;
      alu_func_q      <= '0;
      alu_reg2_q      <= '0;
      alu_reg3_q      <= '0;
      alu_j_address_q <= '0;
      alu_valid_q     <= 1'b0;
      fetch_err_q     <= 1'b0;
      instr_count_q   <= '0;
      for (int unsigned i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_q     <= S_IDLE;
            fetch_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        S_DECODE: begin
          if (instr_q[15:12] == 4'hF) begin
            state_q <= S_HALT;
          end else begin
            alu_opcode_q    <= instr_q[15:12];
            alu_func_q      <= instr_q[2:0];
            alu_reg2_q      <= rs1_val;
            alu_reg3_q      <= rs2_val;
            alu_j_address_q <= instr_q[8:0];
            rd_q            <= instr_q[11:9];
            alu_valid_q     <= 1'b1;
            state_q         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          alu_valid_q <= 1'b0;
          state_q     <= S_WB;
        end
        S_WB: begin
          if (wr_en) rf_q[rd_q] <= alu_result;
          if (alu_opcode_q == 4'hE && alu_status != 4'h0)
            pc_q <= pc_q + alu_j_address_q[7:0];
          else
            pc_q <= pc_q + 8'd1;
          instr_count_q <= instr_count_q + 16'd1;
          wait_q        <= '0;
          state_q       <= S_FETCH;
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_req      = (state_q == S_FETCH);
  assign imem_addr     = pc_q;
  assign busy          = state_q inside {S_FETCH, S_DECODE, S_ISSUE, S_WB};
  assign halted        = (state_q == S_HALT);
  assign fetch_err     = fetch_err_q;
  assign instr_count   = instr_count_q;
  assign alu_opcode    = alu_opcode_q;
  assign alu_func      = alu_func_q;
  assign alu_reg2      = alu_reg2_q;
  assign alu_reg3      = alu_reg3_q;
  assign alu_j_address = alu_j_address_q;
  assign alu_valid     = alu_valid_q;

endmodule

// File: tb/tb_instr_decode_issue.sv
// Testbench for instr_decode_issue: randomized instruction stream with an
// architectural reference model and an issue-packet scoreboard.
module tb_instr_decode_issue;

  localparam logic [7:0]  START_PC = 8'h00;
  localparam int unsigned WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        rst, start, imem_req, imem_ack, alu_valid;
  logic        busy, halted, fetch_err;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata, alu_reg2, alu_reg3, alu_result, instr_count;
  logic [3:0]  alu_opcode, alu_status;
  logic [2:0]  alu_func;
  logic [8:0]  alu_j_address;

  instr_decode_issue #(.START_PC(START_PC), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_opcode(alu_opcode), .alu_func(alu_func),
    .alu_reg2(alu_reg2), .alu_reg3(alu_reg3),
    .alu_j_address(alu_j_address), .alu_valid(alu_valid),
    .alu_result(alu_result), .alu_status(alu_status),
    .busy(busy), .halted(halted), .fetch_err(fetch_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  fn;
    logic [15:0] r2;
    logic [15:0] r3;
    logic [8:0]  j;
  } pkt_t;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: architectural state only
  logic [15:0] m_rf [8];
  logic [7:0]  m_pc;
  logic [15:0] m_cnt;
  pkt_t        exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] a);
`ifdef ISSUE_R0_ZERO_EN
    if (a == 3'd0) return 16'h0000;
`endif
    return m_rf[a];
  endfunction

  function automatic bit m_writes(input logic [3:0] op, input logic [2:0] rd);
`ifdef ISSUE_R0_ZERO_EN
    if (rd == 3'd0) return 1'b0;
`endif
    case (op)
      4'h8, 4'hA, 4'hE, 4'hF: return 1'b0;
      default:                return 1'b1;
    endcase
  endfunction

  // monitor: pop expected issue packet on alu_valid, then check hold in WB
  pkt_t last_pkt;
  bit   hold_chk = 1'b0;
  always @(negedge clk) begin
    if (hold_chk) begin
      hold_chk = 1'b0;
      check("valid_one_cycle", 64'(alu_valid), 64'd0);
      check("issue_hold", 64'({alu_opcode, alu_func, alu_reg2, alu_reg3, alu_j_address}),
            64'(last_pkt));
    end else if (alu_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 64'd1, 64'd0);
      end else begin
        last_pkt = exp_q.pop_front();
        check("issue_pkt", 64'({alu_opcode, alu_func, alu_reg2, alu_reg3, alu_j_address}),
              64'(last_pkt));
        hold_chk = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_pc  = START_PC;
    m_cnt = '0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = imem_req;
    if (!ok) check("req_timeout", 64'd0, 64'd1);
  endtask

  // serve one fetch after 'dly' wait cycles; ALU answers with res/st in WB
  task automatic run_instr(input logic [15:0] ins, input int dly,
                           input logic [15:0] res, input logic [3:0] st);
    bit ok;
    logic [3:0] op;
    wait_req(ok);
    if (!ok) return;
    check("fetch_addr", 64'(imem_addr), 64'(m_pc));
    check("instr_count", 64'(instr_count), 64'(m_cnt));
    check("busy_fetch", 64'(busy), 64'd1);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      check("req_held", 64'({imem_req, imem_addr}), 64'({1'b1, m_pc}));
    end
    imem_ack   = 1'b1;
    imem_rdata = ins;
    alu_result = res;
    alu_status = st;
    op = ins[15:12];
    if (op != 4'hF) begin
      exp_q.push_back('{op: op, fn: ins[2:0], r2: m_read(ins[8:6]),
                        r3: m_read(ins[5:3]), j: ins[8:0]});
      if (m_writes(op, ins[11:9])) m_rf[ins[11:9]] = res;
      if (op == 4'hE && st != 4'h0) m_pc = m_pc + ins[7:0];
      else                          m_pc = m_pc + 8'd1;
      m_cnt = m_cnt + 16'd1;
    end
    @(negedge clk);
    // stray ack / start while decoding must be ignored
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
    start      = 1'($urandom_range(0, 1));
    @(negedge clk);
    imem_ack = 1'b0;
    start    = 1'b0;
  endtask

  task automatic branch_to(input logic [7:0] target);
    logic [7:0] j;
    j = target - m_pc;
    run_instr({4'hE, 3'd0, 1'b0, j}, 0, 16'h0, 4'b0001);
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    alu_result = '0; alu_status = '0;
    do_reset();

    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_flags", 64'({busy, halted, fetch_err, alu_valid}), 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);
    check("rst_pc", 64'(imem_addr), 64'(START_PC));
    check("rst_alu", 64'({alu_opcode, alu_func, alu_reg2, alu_reg3, alu_j_address}), 64'd0);

    pulse_start();
    // add r1,r1,r2 with result 7, then read r1 back through rs1
    run_instr(16'h0250, 2, 16'h0007, 4'h0);
    run_instr(16'h8050, 0, 16'h1234, 4'h0);

    // conditional branch taken / not taken from PC 0x10
    branch_to(8'h10);
    run_instr(16'hE005, 1, 16'h0, 4'b0100);
    branch_to(8'h10);
    run_instr(16'hE005, 0, 16'h0, 4'b0000);

    // PC wrap from 0xFF
    branch_to(8'hFF);
    run_instr(16'h1000, 0, 16'h5555, 4'h0);

    // write R0 then read it
    run_instr(16'h0000, 0, 16'hABCD, 4'h0);
    run_instr(16'h8000, 0, 16'h0, 4'h0);

    // random instruction stream (no halt)
    for (int t = 0; t < 150; t++) begin
      logic [15:0] ins;
      ins = {4'($urandom_range(0, 14)), 12'($urandom)};
      run_instr(ins, $urandom_range(0, 3), 16'($urandom),
                ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom));
    end

    // fetch abort: never acknowledge
    wait_req(ok);
    check("abort_addr_before", 64'(imem_addr), 64'(m_pc));
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("abort_fetch_cycles", 64'(n), 64'(WAIT_MAX + 1));
    check("abort_err_busy", 64'({fetch_err, busy}), 64'b10);
    check("abort_pc", 64'(imem_addr), 64'(m_pc));
    check("abort_count", 64'(instr_count), 64'(m_cnt));

    // restart and halt
    pulse_start();
    run_instr(16'hF000, 1, 16'h0, 4'h0);
    repeat (3) @(negedge clk);
    check("halt_state", 64'({halted, imem_req, busy}), 64'b100);
    pulse_start();
    repeat (3) @(negedge clk);
    check("halt_start_ignored", 64'({halted, imem_req, busy}), 64'b100);
    check("halt_err_sticky", 64'(fetch_err), 64'd1);
    check("halt_pc", 64'(imem_addr), 64'(m_pc));

    do_reset();
    check("rst_from_halt", 64'({halted, fetch_err, busy}), 64'd0);

    // reset in the middle of a fetch
    pulse_start();
    run_instr(16'h2A48, 0, 16'h0F0F, 4'h0);
    wait_req(ok);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req", 64'(imem_req), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_count", 64'(instr_count), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_pc  = START_PC;
    m_cnt = '0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_idle_pc", 64'({imem_req, imem_addr}), 64'({1'b0, START_PC}));

    // recovery after reset: registers read back as zero
    pulse_start();
    run_instr(16'h8248, 0, 16'h0, 4'h0);
    run_instr(16'h3000, 0, 16'h0, 4'h0);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/instr_decode_issue.md
INSTR_DECODE_ISSUE -- requirements
Module: instr_decode_issue

Interface
REQ-001 SHALL provide parameter START_PC, default 8'h00, meaning the PC value loaded at reset.
REQ-002 SHALL provide parameter WAIT_MAX, default 15, meaning the maximum fetch-wait cycles before the fetch is aborted.
REQ-003 SHALL have port clk, input, 1, clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port start, input, 1, begin execution from IDLE.
REQ-006 SHALL have port imem_req, output, 1, fetch request.
REQ-007 SHALL have port imem_addr, output, 8, fetch address (equal to PC).
REQ-008 SHALL have port imem_ack, input, 1, fetch data valid.
REQ-009 SHALL have port imem_rdata, input, 16, instruction word.
REQ-010 SHALL have ALU-side ports: alu_opcode output 4; alu_func output 3; alu_reg2 output 16; alu_reg3 output 16; alu_j_address output 9; alu_valid output 1, issue strobe.
REQ-011 SHALL have ports alu_result, input, 16, ALU result; and alu_status, input, 4, flags {Z,N,C,OF} in bits [3:0].
REQ-012 SHALL have status outputs: busy output 1; halted output 1; fetch_err output 1; instr_count output 16.

Function
REQ-013 SHALL decode the instruction as: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] func; alu_j_address = instr[8:0].
REQ-014 SHALL contain an 8x16 register file; alu_reg2 = R[rs1] and alu_reg3 = R[rs2], both registered in DECODE.
REQ-015 SHALL implement states IDLE, FETCH, DECODE, ISSUE, WB, HALT.
REQ-016 SHALL transition as follows:
- IDLE->FETCH on start.
- FETCH->DECODE on imem_ack, latching imem_rdata.
- DECODE->ISSUE.
- ISSUE->WB.
- WB->FETCH.
- Opcode 4'b1111 in DECODE->HALT.
- HALT is left only by rst.
REQ-017 SHALL hold imem_req high and imem_addr stable for the whole time in FETCH; imem_req SHALL be low in all other states.
REQ-018 SHALL abort the fetch after WAIT_MAX+1 FETCH cycles without imem_ack: go to IDLE, set fetch_err (sticky until rst), PC unchanged.
REQ-019 SHALL pulse alu_valid high for exactly one cycle in ISSUE; opcode, func, reg2, reg3 and j_address SHALL be held from ISSUE through WB.
REQ-020 SHALL sample alu_result and alu_status in WB.
REQ-021 SHALL write R[rd] <= alu_result in WB for opcodes 0000-0111, 1001, 1011, 1100 and 1101; other opcodes SHALL NOT write.
REQ-022 SHALL update PC in WB for opcode 1110: if any alu_status bit is 1, PC <= PC + j_address[7:0] (mod 256); otherwise PC <= PC+1.
REQ-023 SHALL update PC <= PC+1 (mod 256, 8'hFF wraps to 8'h00) in WB for all other opcodes.
REQ-024 SHALL increment instr_count once per WB, wrapping 16'hFFFF to 0.
REQ-025 SHALL drive busy high in FETCH, DECODE, ISSUE and WB, and halted high only in HALT.
REQ-026 SHALL ignore start when not in IDLE.
REQ-027 SHALL ignore imem_ack outside FETCH.
REQ-028 SHALL accept an imem_ack on the same cycle as entering FETCH, giving a minimum of 4 cycles per instruction.

Reset
REQ-029 SHALL, on rst: PC = START_PC; state = IDLE; all registers R0-R7 = 0; imem_req = 0; alu_valid = 0; all other alu_* outputs = 0; busy = halted = fetch_err = 0; instr_count = 0.
REQ-030 SHALL let rst asserted in any state, including mid-FETCH or in HALT, win over all other activity; imem_req SHALL be low from the next edge.

Configuration
REQ-031 SHALL, with macro ISSUE_R0_ZERO_EN defined, hardwire R0 to 16'h0000: writes to rd=0 are discarded and reads return 0.
REQ-032 SHALL, with ISSUE_R0_ZERO_EN undefined, treat R0 as a normal writable register.

Verification
REQ-033 SHALL cover: START_PC=0, imem returns 16'h0250 (add r1,r1,r2) with ack after 2 cycles -> alu_valid one cycle with opcode 0, func 0; alu_result=16'h0007 -> R1=7, PC=1, instr_count=1.
REQ-034 SHALL cover: opcode 1110, j_address=9'h005, PC=8'h10, alu_status=4'b0100 -> PC=8'h15; same with alu_status=0 -> PC=8'h11.
REQ-035 SHALL cover: imem_ack never asserted, WAIT_MAX=15 -> IDLE after 16 FETCH cycles, fetch_err=1, PC unchanged.
REQ-036 SHALL cover: PC=8'hFF with a non-branch instruction -> PC=8'h00; opcode 16'hF000 -> halted=1, imem_req stays 0, start ignored.
REQ-037 SHALL cover: rst pulsed mid-FETCH -> imem_req=0 next cycle, state IDLE, instr_count=0.
REQ-038 SHALL cover: ISSUE_R0_ZERO_EN defined, write 16'hABCD to rd=0 -> a subsequent read of R0 returns 0; with the macro undefined it returns 16'hABCD.
